// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one N:1 data mux between N valid/ready
// requesters. Drives a single registered one-entry output buffer and holds
// the grant across multi-beat packets so packets never interleave.
//
// Handshake: a beat moves on any interface exactly when valid and ready are
// both high on a rising clock edge; valid must not wait on ready. Here
// req_ready is the grant masked by can_accept (buffer empty or draining),
// so at most one requester sees ready at a time.
module mux_rr_scheduler #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N-1:0]                           req_valid,
    input  logic [N-1:0]                           req_last,
    input  logic [N*W-1:0]                         req_data,
    output logic [N-1:0]                           req_ready,
    output logic                                   out_valid,
    output logic                                   out_last,
    output logic [W-1:0]                           out_data,
    input  logic                                   out_ready,
    output logic [N-1:0]                           grant,
    output logic [((N > 2) ? $clog2(N) : 1)-1:0]   sel,
    output logic                                   fsm_state
);

    localparam int SW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state;
    logic [SW-1:0] ptr;        // index that won the last completed packet
    logic [SW-1:0] lock_idx;   // requester owning the packet in progress
    logic [SW-1:0] sel_q;      // last non-idle select, held while grant is zero

    logic [SW-1:0] arb_idx;
    logic          arb_found;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic          can_accept;
    logic          xfer;
    logic          xfer_last;
    logic [W-1:0]  xfer_data;
    int            cand;

    // Round-robin search starting just above the pointer, wrapping modulo N
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = SW'(cand);
            end
        end
    end

    // Grant source: live arbitration in ARB, the locked owner in LOCKED
    always_comb begin
        grant_idx  = (state == LOCKED) ? lock_idx : arb_idx;
        grant_any  = (state == LOCKED) || arb_found;
        grant      = grant_any ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
        sel        = grant_any ? grant_idx : sel_q;
        can_accept = !out_valid || out_ready;
        req_ready  = grant & {N{can_accept}};
        xfer       = grant_any && req_valid[grant_idx] && can_accept;
        xfer_last  = req_last[grant_idx];
        xfer_data  = req_data[int'(grant_idx)*W +: W];
        fsm_state  = (state == LOCKED);
    end

    // Packet FSM, priority pointer, output buffer and select history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            ptr       <= SW'(N-1);
            lock_idx  <= '0;
            sel_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (grant_any) begin
                sel_q <= grant_idx;
            end
            if (xfer) begin
                out_valid <= 1'b1;
                out_last  <= xfer_last;
                out_data  <= xfer_data;
                if (xfer_last) begin
                    state <= ARB;
                    ptr   <= grant_idx;
                end else begin
                    state    <= LOCKED;
                    lock_idx <= grant_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: a table of per-cycle vectors for the
// default N=4/W=8 build, hand sequences for async reset mid-packet, and a
// short run on a second N=2/W=1 instance.
module tb_mux_rr_scheduler;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=4, W=8 instance
    logic [3:0]  rv, rl, rdy, g;
    logic [31:0] rd;
    logic        ov, ol, ordy, st;
    logic [7:0]  od;
    logic [1:0]  s;

    mux_rr_scheduler #(.N(4), .W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv), .req_last(rl), .req_data(rd), .req_ready(rdy),
        .out_valid(ov), .out_last(ol), .out_data(od), .out_ready(ordy),
        .grant(g), .sel(s), .fsm_state(st)
    );

    // N=2, W=1 instance
    logic [1:0] rv2, rl2, rd2, rdy2, g2;
    logic       ov2, ol2, od2, ordy2, s2, st2;

    mux_rr_scheduler #(.N(2), .W(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv2), .req_last(rl2), .req_data(rd2), .req_ready(rdy2),
        .out_valid(ov2), .out_last(ol2), .out_data(od2), .out_ready(ordy2),
        .grant(g2), .sel(s2), .fsm_state(st2)
    );

    // scoreboard counters
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0]  rv;
        logic [3:0]  rl;
        logic [31:0] rd;
        logic        ordy;
        logic [3:0]  g;
        logic [3:0]  rdy;
        logic [1:0]  s;
        logic        ov;
        logic        ol;
        logic [7:0]  od;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] a_rv, input logic [3:0] a_rl, input logic [31:0] a_rd,
                       input logic a_ordy, input logic [3:0] a_g, input logic [3:0] a_rdy,
                       input logic [1:0] a_s, input logic a_ov, input logic a_ol, input logic [7:0] a_od);
        vec_t v;
        v = '{a_rv, a_rl, a_rd, a_ordy, a_g, a_rdy, a_s, a_ov, a_ol, a_od};
        vecs.push_back(v);
    endtask

    initial begin
        // round robin, single-beat packets, no idle cycles
        add(4'b1111, 4'b1111, 32'h13121110, 1, 4'b0001, 4'b0001, 2'd0, 1, 1, 8'h10);
        add(4'b1111, 4'b1111, 32'h13121110, 1, 4'b0010, 4'b0010, 2'd1, 1, 1, 8'h11);
        add(4'b1111, 4'b1111, 32'h13121110, 1, 4'b0100, 4'b0100, 2'd2, 1, 1, 8'h12);
        add(4'b1111, 4'b1111, 32'h13121110, 1, 4'b1000, 4'b1000, 2'd3, 1, 1, 8'h13);
        add(4'b1111, 4'b1111, 32'h13121110, 1, 4'b0001, 4'b0001, 2'd0, 1, 1, 8'h10);
        add(4'b1111, 4'b1111, 32'h13121110, 1, 4'b0010, 4'b0010, 2'd1, 1, 1, 8'h11);
        // requester 2 three-beat packet with a 2-cycle bubble, requester 1 waiting
        add(4'b0110, 4'b0010, 32'h13A01110, 1, 4'b0100, 4'b0100, 2'd2, 1, 0, 8'hA0);
        add(4'b0110, 4'b0010, 32'h13A11110, 1, 4'b0100, 4'b0100, 2'd2, 1, 0, 8'hA1);
        add(4'b0010, 4'b0010, 32'h13A11110, 1, 4'b0100, 4'b0100, 2'd2, 0, 0, 8'hA1);
        add(4'b0010, 4'b0010, 32'h13A11110, 1, 4'b0100, 4'b0100, 2'd2, 0, 0, 8'hA1);
        add(4'b0110, 4'b0110, 32'h13A21110, 1, 4'b0100, 4'b0100, 2'd2, 1, 1, 8'hA2);
        add(4'b0010, 4'b0010, 32'h13A21110, 1, 4'b0010, 4'b0010, 2'd1, 1, 1, 8'h11);
        // wrap-around: requester 3 alone, then 0 and 3 -> 0 wins
        add(4'b1000, 4'b1000, 32'h33A21110, 1, 4'b1000, 4'b1000, 2'd3, 1, 1, 8'h33);
        add(4'b1001, 4'b1001, 32'h33A21110, 1, 4'b0001, 4'b0001, 2'd0, 1, 1, 8'h10);
        // stall: 0x55 buffered for 5 cycles of out_ready=0
        add(4'b0010, 4'b0010, 32'h13125510, 1, 4'b0010, 4'b0010, 2'd1, 1, 1, 8'h55);
        for (int i = 0; i < 5; i++)
            add(4'b0101, 4'b0101, 32'h13225510, 0, 4'b0100, 4'b0000, 2'd2, 1, 1, 8'h55);
        add(4'b0101, 4'b0101, 32'h13225510, 1, 4'b0100, 4'b0100, 2'd2, 1, 1, 8'h22);
        // idle: drain, select holds
        add(4'b0000, 4'b0000, 32'h13225510, 1, 4'b0000, 4'b0000, 2'd2, 0, 1, 8'h22);

        rv = '0; rl = '0; rd = '0; ordy = 1'b1;
        rv2 = '0; rl2 = '0; rd2 = '0; ordy2 = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, ov}, 32'd0);
        chk("reset_out_last", {31'd0, ol}, 32'd0);
        chk("reset_out_data", {24'd0, od}, 32'd0);
        chk("reset_grant", {28'd0, g}, 32'd0);
        chk("reset_sel", {30'd0, s}, 32'd0);
        chk("reset_state", {31'd0, st}, 32'd0);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            rv = vecs[i].rv; rl = vecs[i].rl; rd = vecs[i].rd; ordy = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_grant", i), {28'd0, g}, {28'd0, vecs[i].g});
            chk($sformatf("v%0d_req_ready", i), {28'd0, rdy}, {28'd0, vecs[i].rdy});
            chk($sformatf("v%0d_sel", i), {30'd0, s}, {30'd0, vecs[i].s});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {31'd0, ov}, {31'd0, vecs[i].ov});
            chk($sformatf("v%0d_out_last", i), {31'd0, ol}, {31'd0, vecs[i].ol});
            chk($sformatf("v%0d_out_data", i), {24'd0, od}, {24'd0, vecs[i].od});
        end

        // async reset during a locked packet from requester 1 (pointer is 2)
        rv = 4'b0010; rl = 4'b0000; rd = 32'h13127710; ordy = 1'b1;
        #1;
        chk("lock_grant", {28'd0, g}, 32'h2);
        @(posedge clk); #1;
        chk("lock_beat0", {24'd0, od}, 32'h77);
        chk("lock_state", {31'd0, st}, 32'd1);
        rd = 32'h13127810;
        @(posedge clk); #1;
        chk("lock_beat1", {24'd0, od}, 32'h78);
        #3;
        rst_n = 1'b0; rv = 4'b0000;
        #1;
        chk("midrst_out_valid", {31'd0, ov}, 32'd0);
        chk("midrst_grant", {28'd0, g}, 32'd0);
        chk("midrst_state", {31'd0, st}, 32'd0);
        chk("midrst_out_data", {24'd0, od}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv = 4'b0011; rl = 4'b0011; rd = 32'h13121110;
        #1;
        chk("postrst_grant", {28'd0, g}, 32'h1);
        @(posedge clk); #1;
        chk("postrst_out_data", {24'd0, od}, 32'h10);
        chk("postrst_out_valid", {31'd0, ov}, 32'd1);
        rv = 4'b0000;

        // N=2, W=1: alternating single-beat requests
        rv2 = 2'b11; rl2 = 2'b11; rd2 = 2'b10; ordy2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic exp_s;
            exp_s = (i == 1);
            #1;
            chk($sformatf("n2_sel%0d", i), {31'd0, s2}, {31'd0, exp_s});
            chk($sformatf("n2_grant%0d", i), {30'd0, g2}, exp_s ? 32'h2 : 32'h1);
            chk($sformatf("n2_ready_onehot%0d", i), {31'd0, ($countones(rdy2) <= 1)}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("n2_out_data%0d", i), {31'd0, od2}, {31'd0, exp_s});
        end
        rv2 = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
